// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_loader
//  Description : Byte-wide program loader feeding a 32-bit instruction fetch
//                port. A load session streams bytes into a 2**ADDR_W byte
//                memory; fetches return four bytes at PC in the configured
//                byte order, or fault when the image cannot serve them.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
   parameter int ADDR_W     = 10,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   // program-load channel
   input  logic              load_en,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   output logic              load_ready,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count,
   // fetch channel
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] PC,
   output logic              fetch_valid,
   output logic [31:0]       Instruction_Code,
   output logic              fetch_fault
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_t;

   // Memory depth expressed in the load_count width so no comparison wraps.
   localparam logic [ADDR_W:0] c_depth      = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] c_last       = c_depth - 1'b1;
   localparam logic [ADDR_W:0] c_word_bytes = (ADDR_W+1)'(4);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W:0]   r_count;        // doubles as the write pointer
   logic              r_load_en_d;    // previous load_en, for reload edge detect
   logic              r_load_done;
   logic              r_fetch_valid;
   logic              r_fetch_fault;
   logic [31:0]       r_code;
   logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

   logic              w_load_ready;
   logic              w_accept;
   logic              w_start;        // session begins at this edge
   logic              w_exit;         // session ends at this edge
   logic              w_fault;
   logic [ADDR_W:0]   w_pc_end;
   logic [ADDR_W-1:0] w_addr1;
   logic [ADDR_W-1:0] w_addr2;
   logic [ADDR_W-1:0] w_addr3;
   logic [7:0]        w_b0;
   logic [7:0]        w_b1;
   logic [7:0]        w_b2;
   logic [7:0]        w_b3;
   logic [31:0]       w_word;

   // Byte acceptance: only while loading and while the memory still has room.
   assign w_load_ready = (r_state == LOADING) && (r_count < c_depth);
   assign w_accept     = load_valid && w_load_ready;

   // Next-state logic; a reload from READY needs a fresh rising load_en so a
   // held load_en after filling the memory does not restart the session.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_exit       = 1'b0;
      case (r_state)
         EMPTY: begin
            if (load_en) begin
               w_state_next = LOADING;
               w_start      = 1'b1;
            end
         end
         LOADING: begin
            if (!load_en || (w_accept && (r_count == c_last))) begin
               w_state_next = READY;
               w_exit       = 1'b1;
            end
         end
         READY: begin
            if (load_en && !r_load_en_d) begin
               w_state_next = LOADING;
               w_start      = 1'b1;
            end
         end
         default: begin
            w_state_next = EMPTY;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Write pointer / byte count, load_en history and the end-of-load pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count     <= '0;
         r_load_en_d <= 1'b0;
         r_load_done <= 1'b0;
      end else begin
         r_load_en_d <= load_en;
         r_load_done <= w_exit;
         if (w_start) begin
            r_count <= '0;
         end else if (w_accept) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // Program memory; intentionally never cleared so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_count[ADDR_W-1:0]] <= load_byte;
      end
   end

   // Fetch address arithmetic; the end address carries one extra bit so a
   // fetch near the top of memory is compared without wrapping.
   assign w_pc_end = {1'b0, PC} + c_word_bytes;
   assign w_addr1  = PC + ADDR_W'(1);
   assign w_addr2  = PC + ADDR_W'(2);
   assign w_addr3  = PC + ADDR_W'(3);
   assign w_b0     = r_mem[PC];
   assign w_b1     = r_mem[w_addr1];
   assign w_b2     = r_mem[w_addr2];
   assign w_b3     = r_mem[w_addr3];
   assign w_word   = BIG_ENDIAN ? {w_b0, w_b1, w_b2, w_b3}
                                : {w_b3, w_b2, w_b1, w_b0};

   // A starting reload wins over a simultaneous fetch, hence w_start here.
   assign w_fault = (r_state != READY) || w_start ||
                    (PC[1:0] != 2'b00) || (w_pc_end > r_count);

   // Registered fetch response; the code word holds between responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_code        <= '0;
      end else begin
         r_fetch_valid <= fetch_req;
         if (fetch_req) begin
            r_fetch_fault <= w_fault;
            r_code        <= w_fault ? 32'h0000_0000 : w_word;
         end else begin
            r_fetch_fault <= 1'b0;
         end
      end
   end

   assign load_ready       = w_load_ready;
   assign load_done        = r_load_done;
   assign load_count       = r_count;
   assign fetch_valid      = r_fetch_valid;
   assign fetch_fault      = r_fetch_fault;
   assign Instruction_Code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_loader
//  Description : Self-checking bench for inst_mem_loader. Two 1 KiB instances
//                (big and little endian) share stimulus; a 16-byte instance
//                covers the memory-full boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // shared stimulus for instances a (big endian) and b (little endian)
   logic       load_en_ab, load_valid_ab, fetch_req_ab;
   logic [7:0] load_byte_ab;
   logic [9:0] pc_ab;
   logic       load_ready_a, load_done_a, fetch_valid_a, fetch_fault_a;
   logic       load_ready_b, load_done_b, fetch_valid_b, fetch_fault_b;
   logic [10:0] load_count_a, load_count_b;
   logic [31:0] code_a, code_b;

   // stimulus for the 16-byte instance c
   logic       load_en_c, load_valid_c, fetch_req_c;
   logic [7:0] load_byte_c;
   logic [3:0] pc_c;
   logic       load_ready_c, load_done_c, fetch_valid_c, fetch_fault_c;
   logic [4:0] load_count_c;
   logic [31:0] code_c;

   inst_mem_loader #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) u_dut_a (
      .clk(clk), .reset(reset),
      .load_en(load_en_ab), .load_valid(load_valid_ab), .load_byte(load_byte_ab),
      .load_ready(load_ready_a), .load_done(load_done_a), .load_count(load_count_a),
      .fetch_req(fetch_req_ab), .PC(pc_ab), .fetch_valid(fetch_valid_a),
      .Instruction_Code(code_a), .fetch_fault(fetch_fault_a));

   inst_mem_loader #(.ADDR_W(10), .BIG_ENDIAN(1'b0)) u_dut_b (
      .clk(clk), .reset(reset),
      .load_en(load_en_ab), .load_valid(load_valid_ab), .load_byte(load_byte_ab),
      .load_ready(load_ready_b), .load_done(load_done_b), .load_count(load_count_b),
      .fetch_req(fetch_req_ab), .PC(pc_ab), .fetch_valid(fetch_valid_b),
      .Instruction_Code(code_b), .fetch_fault(fetch_fault_b));

   inst_mem_loader #(.ADDR_W(4), .BIG_ENDIAN(1'b1)) u_dut_c (
      .clk(clk), .reset(reset),
      .load_en(load_en_c), .load_valid(load_valid_c), .load_byte(load_byte_c),
      .load_ready(load_ready_c), .load_done(load_done_c), .load_count(load_count_c),
      .fetch_req(fetch_req_c), .PC(pc_c), .fetch_valid(fetch_valid_c),
      .Instruction_Code(code_c), .fetch_fault(fetch_fault_c));

   typedef struct packed {
      logic        flt;
      logic [31:0] code;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   int checks   = 0;
   int failures = 0;
   int done_a   = 0;
   int done_b   = 0;
   int done_c   = 0;
   int cnt_ab   = 0;
   logic exp_va = 1'b0;
   logic exp_vc = 1'b0;

   logic [7:0] mem_ab [0:1023];
   logic [7:0] mem_c  [0:15];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input bit be);
      return be ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte_ab(input logic [7:0] b);
      load_valid_ab = 1'b1;
      load_byte_ab  = b;
      mem_ab[cnt_ab] = b;
      cnt_ab++;
      tick();
   endtask

   task automatic end_load_ab();
      load_valid_ab = 1'b0;
      load_en_ab    = 1'b0;
      tick();
   endtask

   task automatic fetch_ab(input int pc, input bit flt);
      logic [31:0] wa, wb;
      wa = 32'h0;
      wb = 32'h0;
      if (!flt) begin
         wa = word_of(mem_ab[pc], mem_ab[pc+1], mem_ab[pc+2], mem_ab[pc+3], 1'b1);
         wb = word_of(mem_ab[pc], mem_ab[pc+1], mem_ab[pc+2], mem_ab[pc+3], 1'b0);
      end
      fetch_req_ab = 1'b1;
      pc_ab        = 10'(pc);
      qa.push_back(exp_t'({flt, wa}));
      qb.push_back(exp_t'({flt, wb}));
      tick();
   endtask

   task automatic fetch_c(input int pc, input bit flt);
      logic [31:0] wc;
      wc = 32'h0;
      if (!flt) wc = word_of(mem_c[pc], mem_c[pc+1], mem_c[pc+2], mem_c[pc+3], 1'b1);
      fetch_req_c = 1'b1;
      pc_c        = 4'(pc);
      qc.push_back(exp_t'({flt, wc}));
      tick();
   endtask

   // Remember which edges carried a fetch request.
   always @(posedge clk) begin
      exp_va <= fetch_req_ab;
      exp_vc <= fetch_req_c;
   end

   // Scoreboard: compare each response against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (load_done_a) done_a++;
      if (load_done_b) done_b++;
      if (load_done_c) done_c++;
      if (exp_va || fetch_valid_a) check("a_valid", fetch_valid_a, exp_va);
      if (exp_va || fetch_valid_b) check("b_valid", fetch_valid_b, exp_va);
      if (exp_vc || fetch_valid_c) check("c_valid", fetch_valid_c, exp_vc);
      if (fetch_valid_a) begin
         if (qa.size() == 0) check("a_extra", 1, 0);
         else begin
            e = qa.pop_front();
            check("a_fault", fetch_fault_a, e.flt);
            check("a_code", code_a, e.code);
         end
      end
      if (fetch_valid_b) begin
         if (qb.size() == 0) check("b_extra", 1, 0);
         else begin
            e = qb.pop_front();
            check("b_fault", fetch_fault_b, e.flt);
            check("b_code", code_b, e.code);
         end
      end
      if (fetch_valid_c) begin
         if (qc.size() == 0) check("c_extra", 1, 0);
         else begin
            e = qc.pop_front();
            check("c_fault", fetch_fault_c, e.flt);
            check("c_code", code_c, e.code);
         end
      end
   end

   initial begin
      reset = 1'b1;
      load_en_ab = 1'b0; load_valid_ab = 1'b0; load_byte_ab = 8'h0;
      fetch_req_ab = 1'b0; pc_ab = 10'h0;
      load_en_c = 1'b0; load_valid_c = 1'b0; load_byte_c = 8'h0;
      fetch_req_c = 1'b0; pc_c = 4'h0;
      repeat (3) tick();

      // reset state
      check("rst_count_a", load_count_a, 0);
      check("rst_ready_a", load_ready_a, 0);
      check("rst_done_a",  load_done_a, 0);
      check("rst_valid_a", fetch_valid_a, 0);
      check("rst_fault_a", fetch_fault_a, 0);
      check("rst_code_a",  code_a, 0);
      check("rst_count_c", load_count_c, 0);
      reset = 1'b0;
      tick();

      // four-byte image, both byte orders
      load_en_ab = 1'b1;
      cnt_ab = 0;
      tick();
      push_byte_ab(8'h8D);
      push_byte_ab(8'h61);
      push_byte_ab(8'h00);
      push_byte_ab(8'h0C);
      end_load_ab();
      tick();
      check("img4_count_a", load_count_a, 4);
      check("img4_done_a", done_a, 1);
      check("img4_done_b", done_b, 1);
      fetch_ab(0, 1'b0);
      fetch_req_ab = 1'b0;
      check("img4_code_a", code_a, 32'h8D61000C);
      check("img4_code_b", code_b, 32'h0C00618D);
      check("img4_fault_a", fetch_fault_a, 0);
      tick();
      check("hold_code_a", code_a, 32'h8D61000C);
      check("hold_valid_a", fetch_valid_a, 0);

      // reload request collides with a fetch: the load wins
      load_en_ab = 1'b1;
      fetch_ab(0, 1'b1);
      fetch_req_ab = 1'b0;
      check("reload_fault_a", fetch_fault_a, 1);
      check("reload_count_a", load_count_a, 0);
      check("reload_ready_a", load_ready_a, 1);
      cnt_ab = 0;
      for (int i = 0; i < 8; i++) push_byte_ab(8'(8'h11 * (i + 1)));
      end_load_ab();
      tick();
      check("img8_count_a", load_count_a, 8);
      check("img8_done_a", done_a, 2);

      // alignment and bound checks on an 8-byte image
      fetch_ab(2, 1'b1);
      fetch_ab(8, 1'b1);
      fetch_ab(4, 1'b0);
      fetch_ab(0, 1'b0);
      fetch_ab(1020, 1'b1);
      fetch_req_ab = 1'b0;
      repeat (2) tick();

      // reset in the middle of a load session
      load_en_ab = 1'b1;
      tick();
      cnt_ab = 0;
      for (int i = 0; i < 3; i++) push_byte_ab(8'(8'hC0 + i));
      reset = 1'b1;
      load_valid_ab = 1'b0;
      load_en_ab = 1'b0;
      tick();
      check("midrst_count_a", load_count_a, 0);
      check("midrst_ready_a", load_ready_a, 0);
      reset = 1'b0;
      cnt_ab = 0;
      repeat (2) tick();
      check("midrst_done_a", done_a, 2);
      fetch_ab(0, 1'b1);
      fetch_req_ab = 1'b0;
      repeat (2) tick();
      check("midrst_count2_a", load_count_a, 0);

      // 16-byte memory: stream 20 bytes with load_en held
      load_en_c = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         load_valid_c = 1'b1;
         load_byte_c  = 8'(8'hA0 + i);
         if (i < 16) mem_c[i] = 8'(8'hA0 + i);
         check($sformatf("c_ready_%0d", i), load_ready_c, (i < 16));
         tick();
      end
      load_valid_c = 1'b0;
      tick();
      check("full_count_c", load_count_c, 16);
      check("full_ready_c", load_ready_c, 0);
      check("full_done_c", done_c, 1);
      load_en_c = 1'b0;
      tick();
      check("full_done2_c", done_c, 1);
      fetch_c(12, 1'b0);
      fetch_c(0, 1'b0);
      fetch_c(14, 1'b1);
      fetch_req_c = 1'b0;
      repeat (3) tick();

      check("qa_drained", qa.size(), 0);
      check("qb_drained", qb.size(), 0);
      check("qc_drained", qc.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1, meaning 1 = lowest address holds instruction MSB, 0 = lowest address holds LSB.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port load_en  input  1  request/hold program-load session.
REQ-006 The block SHALL have port load_valid  input  1  load_byte carries a byte.
REQ-007 The block SHALL have port load_byte  input  8  program byte.
REQ-008 The block SHALL have port load_ready  output  1  block accepts a byte this cycle.
REQ-009 The block SHALL have port load_done  output  1  one-cycle pulse at end of load session.
REQ-010 The block SHALL have port load_count  output  ADDR_W+1  bytes in current image.
REQ-011 The block SHALL have port fetch_req  input  1  fetch request.
REQ-012 The block SHALL have port PC  input  ADDR_W  byte address of fetch.
REQ-013 The block SHALL have port fetch_valid  output  1  Instruction_Code/fetch_fault valid.
REQ-014 The block SHALL have port Instruction_Code  output  32  fetched instruction.
REQ-015 The block SHALL have port fetch_fault  output  1  fetch rejected.

Function
REQ-016 The FSM SHALL have states EMPTY, LOADING, READY.
- EMPTY -> LOADING when load_en=1; READY -> LOADING when load_en=1 (reload).
- LOADING -> READY when load_en=0, or on the accepting cycle of byte 2**ADDR_W.
REQ-017 Entering LOADING SHALL clear the write pointer and load_count to 0.
REQ-018 load_ready SHALL be 1 only in LOADING with write pointer < 2**ADDR_W.
REQ-019 A byte SHALL be written at the write pointer when load_valid & load_ready; pointer and load_count then increment by 1.
REQ-020 load_done SHALL pulse high exactly one cycle, the cycle after LOADING exits.
REQ-021 A fetch SHALL be accepted every cycle fetch_req=1, in any state.
- fetch_valid=1 exactly one cycle later; one result per request; back-to-back supported.
REQ-022 Fetch data SHALL be {M[PC],M[PC+1],M[PC+2],M[PC+3]} when BIG_ENDIAN=1 and {M[PC+3],M[PC+2],M[PC+1],M[PC]} when BIG_ENDIAN=0, registered.
REQ-023 fetch_fault SHALL be 1, with Instruction_Code=32'h0000_0000, if any of:
- state != READY at the request edge;
- PC[1:0] != 0;
- PC+4 > load_count, computed in ADDR_W+1 bits with no wrap.
REQ-024 When load_en rises in READY in the same cycle as fetch_req, the load SHALL take priority and that fetch SHALL fault.
REQ-025 Instruction_Code SHALL hold its last value while fetch_valid=0.
REQ-026 Memory contents SHALL NOT be cleared by reset or by a new load; only bytes below load_count are fetchable.

Reset
REQ-027 While reset=1, the FSM SHALL be in EMPTY with load_count=0, the write pointer at 0, and load_ready, load_done, fetch_valid, fetch_fault and Instruction_Code all 0.
REQ-028 Reset asserted mid-load SHALL abandon the session with no load_done pulse; a later fetch SHALL fault until a new load completes.

Verification
REQ-029 Load bytes 8D 61 00 0C, drop load_en, fetch PC=0 with BIG_ENDIAN=1 -> next cycle fetch_valid=1, Instruction_Code=32'h8D61000C, fetch_fault=0, load_count=4, one load_done pulse.
REQ-030 Same image with BIG_ENDIAN=0, fetch PC=0 -> Instruction_Code=32'h0C00618D.
REQ-031 Image of 8 bytes, fetch PC=2 and PC=8 -> fetch_fault=1 both, Instruction_Code=0; fetch PC=4 -> fetch_fault=0.
REQ-032 ADDR_W=4, stream 20 bytes with load_en held -> load_ready drops after 16, load_count=16, READY, load_done pulse; fetch PC=12 succeeds.
REQ-033 Assert reset after 3 of 8 bytes, release, fetch PC=0 -> fetch_fault=1, load_count=0, no load_done.
REQ-034 In READY, assert load_en and fetch_req in the same cycle -> fetch_fault=1, state LOADING, load_count=0.
